// File: rtl/decoder_scan_pkg.sv
// Shared definitions for the decoder_scan strobe generator: mode codes,
// FSM state encoding and a one-hot helper sized for the widest select bus.
package decoder_scan_pkg;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 1 << MAX_SEL_W;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_SCAN   = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIRECT = 2'd1,
        ST_SCAN   = 2'd2,
        ST_SWEEP  = 2'd3
    } state_e;

    // Callers narrow the result with a size cast to their own output width.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        logic [MAX_OUT_W-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/decoder_scan_dwell_timer.sv
// Dwell timer: counts 0..DWELL-1 while run is high and pulses tick on the
// last count, so a strobe held from a clear sees tick after DWELL cycles.
module decoder_scan_dwell_timer #(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CNT_W = $clog2(DWELL + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = run && (cnt_q == CNT_LAST);

    // Next count: clear wins, otherwise advance and wrap while running.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with direct select, continuous scan
// and one-shot sweep modes, plus selectable output polarity.
//
// state     | meaning
// ST_IDLE   | outputs inactive, waiting for a mode to launch
// ST_DIRECT | q follows sel each cycle
// ST_SCAN   | rotating strobe, DWELL cycles per index, wraps forever
// ST_SWEEP  | single pass 0..OUT_W-1, then done pulse and back to idle
module decoder_scan
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W  = 3,
    parameter int DWELL  = 4,
    parameter bit INVERT = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [1:0]            mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  start,
    output logic [(2**SEL_W)-1:0] q,
    output logic [SEL_W-1:0]      idx,
    output logic                  busy,
    output logic                  done
);

    localparam int OUT_W = 2 ** SEL_W;
    localparam logic [OUT_W-1:0] Q_IDLE   = {OUT_W{INVERT}};
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_W - 1);

    state_e             state_q, state_d;
    logic [OUT_W-1:0]   q_q, q_d;
    logic [SEL_W-1:0]   idx_q, idx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               timer_run;
    logic               timer_clear;
    logic               timer_tick;
    logic               last_tick;
    logic [SEL_W-1:0]   step_idx;

    function automatic logic [OUT_W-1:0] active(input logic [SEL_W-1:0] i);
        return OUT_W'(onehot(MAX_SEL_W'(i))) ^ {OUT_W{INVERT}};
    endfunction

    // Timer restarts on every state change so each run begins a fresh dwell.
    assign timer_run   = (state_q == ST_SCAN) || (state_q == ST_SWEEP);
    assign timer_clear = (state_d != state_q);
    assign last_tick   = timer_tick && (idx_q == LAST_IDX);

    decoder_scan_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .run   (timer_run),
        .tick  (timer_tick)
    );

    // State and registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= Q_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state selection; a dropped enable returns to idle from anywhere.
    always_comb begin
        state_d = state_q;
        if (!enable) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    case (mode)
                        MODE_DIRECT: state_d = ST_DIRECT;
                        MODE_SCAN:   state_d = ST_SCAN;
                        MODE_SWEEP:  state_d = start ? ST_SWEEP : ST_IDLE;
                        MODE_RSVD:   state_d = ST_IDLE;
                        default:     state_d = ST_IDLE;
                    endcase
                end
                ST_DIRECT: if (mode != MODE_DIRECT) state_d = ST_IDLE;
                ST_SCAN:   if (mode != MODE_SCAN) state_d = ST_IDLE;
                ST_SWEEP:  if ((mode != MODE_SWEEP) || last_tick) state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // Output values for the state being entered; idx holds when idle.
    always_comb begin
        step_idx = (state_q != state_d) ? '0
                 : (timer_tick ? idx_q + 1'b1 : idx_q);
        q_d    = Q_IDLE;
        idx_d  = idx_q;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_d)
            ST_DIRECT: begin
                idx_d = sel;
                q_d   = active(sel);
            end
            ST_SCAN, ST_SWEEP: begin
                idx_d  = step_idx;
                q_d    = active(step_idx);
                busy_d = 1'b1;
            end
            default: begin
                done_d = (state_q == ST_SWEEP) && enable
                      && (mode == MODE_SWEEP) && last_tick;
            end
        endcase
    end

    assign q    = q_q;
    assign idx  = idx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Self-checking bench for decoder_scan: three parameterisations, a vector
// table, hand-written corner sequences and a randomized run against a model.
module tb_decoder_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT A: SEL_W=3, DWELL=2, active-high
    logic       a_rst, a_en, a_start;
    logic [1:0] a_mode;
    logic [2:0] a_sel, a_idx;
    logic [7:0] a_q;
    logic       a_busy, a_done;

    // DUT B: SEL_W=2, DWELL=1, active-high
    logic       b_rst, b_en, b_start;
    logic [1:0] b_mode, b_sel, b_idx;
    logic [3:0] b_q;
    logic       b_busy, b_done;

    // DUT C: SEL_W=3, DWELL=3, active-low
    logic       c_rst, c_en, c_start;
    logic [1:0] c_mode;
    logic [2:0] c_sel, c_idx;
    logic [7:0] c_q;
    logic       c_busy, c_done;

    decoder_scan #(.SEL_W(3), .DWELL(2), .INVERT(1'b0)) u_a (
        .clk(clk), .rst(a_rst), .enable(a_en), .mode(a_mode), .sel(a_sel),
        .start(a_start), .q(a_q), .idx(a_idx), .busy(a_busy), .done(a_done));

    decoder_scan #(.SEL_W(2), .DWELL(1), .INVERT(1'b0)) u_b (
        .clk(clk), .rst(b_rst), .enable(b_en), .mode(b_mode), .sel(b_sel),
        .start(b_start), .q(b_q), .idx(b_idx), .busy(b_busy), .done(b_done));

    decoder_scan #(.SEL_W(3), .DWELL(3), .INVERT(1'b1)) u_c (
        .clk(clk), .rst(c_rst), .enable(c_en), .mode(c_mode), .sel(c_sel),
        .start(c_start), .q(c_q), .idx(c_idx), .busy(c_busy), .done(c_done));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit         rst;
        bit         en;
        logic [1:0] mode;
        logic [2:0] sel;
        bit         start;
        logic [7:0] q;
        logic [2:0] idx;
        bit         busy;
        bit         done;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit en, input logic [1:0] md,
                                input logic [2:0] s, input bit st, input logic [7:0] eq,
                                input logic [2:0] ei, input bit eb, input bit ed);
        vec_t v;
        v.rst = r; v.en = en; v.mode = md; v.sel = s; v.start = st;
        v.q = eq; v.idx = ei; v.busy = eb; v.done = ed;
        tbl.push_back(v);
    endfunction

    // Behavioural model of DUT A: position within a run is elapsed cycles,
    // the strobe index is elapsed/DWELL.
    localparam int A_DW = 2;
    localparam int A_OW = 8;
    int         m_st;       // 0 idle, 1 direct, 2 scan, 3 sweep
    int         m_el;
    int         m_idx;
    logic [7:0] m_q;
    bit         m_busy, m_done;

    task automatic model_step(input bit r, input bit en, input logic [1:0] md,
                              input logic [2:0] s, input bit st);
        m_done = 1'b0;
        if (r) begin
            m_st = 0; m_idx = 0; m_q = '0; m_busy = 1'b0;
        end else if (!en) begin
            m_st = 0; m_q = '0; m_busy = 1'b0;
        end else begin
            case (m_st)
                0: begin
                    if (md == 2'd0) begin
                        m_st = 1; m_idx = int'(s);
                    end else if (md == 2'd1 || (md == 2'd2 && st)) begin
                        m_st = (md == 2'd1) ? 2 : 3; m_el = 0; m_idx = 0;
                    end
                end
                1: if (md == 2'd0) m_idx = int'(s); else m_st = 0;
                2: begin
                    if (md == 2'd1) begin
                        m_el++; m_idx = (m_el / A_DW) % A_OW;
                    end else m_st = 0;
                end
                default: begin
                    if (md == 2'd2) begin
                        m_el++;
                        if (m_el == A_OW * A_DW) begin
                            m_st = 0; m_done = 1'b1;
                        end else m_idx = m_el / A_DW;
                    end else m_st = 0;
                end
            endcase
            m_busy = (m_st >= 2);
            m_q    = (m_st >= 1) ? 8'(1 << m_idx) : 8'h00;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen_done;
        int n;
        a_rst = 1; a_en = 0; a_mode = 0; a_sel = 0; a_start = 0;
        b_rst = 1; b_en = 0; b_mode = 0; b_sel = 0; b_start = 0;
        c_rst = 1; c_en = 0; c_mode = 0; c_sel = 0; c_start = 0;

        // Vector table for DUT A: reset, DIRECT, SCAN with wrap, exit.
        add(1, 0, 2'd0, 3'd0, 0, 8'h00, 3'd0, 0, 0);
        add(0, 1, 2'd0, 3'd5, 0, 8'h20, 3'd5, 0, 0);
        add(0, 1, 2'd0, 3'd0, 0, 8'h01, 3'd0, 0, 0);
        add(0, 1, 2'd0, 3'd7, 0, 8'h80, 3'd7, 0, 0);
        add(0, 1, 2'd1, 3'd7, 0, 8'h00, 3'd7, 0, 0);
        for (int k = 0; k < 18; k++)
            add(0, 1, 2'd1, 3'd3, 0, 8'(1 << ((k / 2) % 8)), 3'((k / 2) % 8), 1, 0);
        add(0, 1, 2'd0, 3'd2, 0, 8'h00, 3'd0, 0, 0);
        add(0, 1, 2'd0, 3'd2, 0, 8'h04, 3'd2, 0, 0);
        add(0, 0, 2'd0, 3'd6, 0, 8'h00, 3'd2, 0, 0);

        foreach (tbl[i]) begin
            a_rst = tbl[i].rst; a_en = tbl[i].en; a_mode = tbl[i].mode;
            a_sel = tbl[i].sel; a_start = tbl[i].start;
            tick();
            chk($sformatf("tbl_q[%0d]", i), 32'(a_q), 32'(tbl[i].q));
            chk($sformatf("tbl_idx[%0d]", i), 32'(a_idx), 32'(tbl[i].idx));
            chk($sformatf("tbl_busy_done[%0d]", i), {30'd0, a_busy, a_done},
                {30'd0, tbl[i].busy, tbl[i].done});
        end

        // Reserved mode with start held: nothing may happen.
        a_en = 1; a_mode = 2'b11; a_start = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("rsvd_idle", {22'd0, a_q, a_busy, a_done}, 32'd0);
        end
        a_start = 0;

        // DUT B: DWELL=1 sweep, second start ignored, done pulse.
        b_rst = 0;
        tick();
        chk("b_reset_q", 32'(b_q), 32'h0);
        b_en = 1; b_mode = 2'b10; b_start = 1;
        tick();
        chk("b_sweep_q0", {26'd0, b_q, b_busy, b_done}, {26'd0, 4'h1, 1'b1, 1'b0});
        b_start = 0;
        tick();
        chk("b_sweep_q1", {26'd0, b_q, b_busy, b_done}, {26'd0, 4'h2, 1'b1, 1'b0});
        b_start = 1;
        tick();
        chk("b_sweep_q2", {26'd0, b_q, b_busy, b_done}, {26'd0, 4'h4, 1'b1, 1'b0});
        b_start = 0;
        tick();
        chk("b_sweep_q3", {26'd0, b_q, b_busy, b_done}, {26'd0, 4'h8, 1'b1, 1'b0});
        chk("b_sweep_idx3", 32'(b_idx), 32'd3);
        tick();
        chk("b_sweep_done", {26'd0, b_q, b_busy, b_done}, {26'd0, 4'h0, 1'b0, 1'b1});
        tick();
        chk("b_done_single", {26'd0, b_q, b_busy, b_done}, 32'd0);
        b_en = 0; b_start = 1;
        tick();
        chk("b_start_en_fall", {26'd0, b_q, b_busy, b_done}, 32'd0);
        b_en = 1; b_start = 0;
        tick();
        chk("b_no_launch", {26'd0, b_q, b_busy, b_done}, 32'd0);

        // DUT C: active-low DIRECT, then reset abort mid-sweep.
        c_rst = 0; c_en = 1; c_mode = 2'b00; c_sel = 3'd3;
        tick();
        chk("c_direct_inv", 32'(c_q), 32'hF7);
        c_en = 0;
        tick();
        chk("c_disable_inv", 32'(c_q), 32'hFF);
        c_en = 1; c_mode = 2'b10; c_start = 1;
        tick();
        chk("c_sweep_start", {23'd0, c_q, c_busy}, {23'd0, 8'hFE, 1'b1});
        c_start = 0;
        seen_done = 0;
        n = 0;
        while (c_idx !== 3'd2 && n < 20) begin
            tick();
            if (c_done) seen_done = 1;
            n++;
        end
        chk("c_reach_idx2", 32'(c_idx), 32'd2);
        chk("c_idx2_q", 32'(c_q), 32'hFB);
        c_rst = 1;
        tick();
        chk("c_abort", {20'd0, c_q, c_idx, c_busy}, {20'd0, 8'hFF, 3'd0, 1'b0});
        c_rst = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (c_done) seen_done = 1;
        end
        chk("c_no_done", 32'(seen_done), 32'd0);

        // Randomized run of DUT A against the model.
        a_rst = 1; a_en = 1; a_mode = 0; a_sel = 0; a_start = 0;
        model_step(1, 1, 0, 0, 0);
        tick();
        for (int k = 0; k < 600; k++) begin
            a_rst = ($urandom_range(0, 99) == 0);
            a_en  = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 19) == 0) a_mode = 2'($urandom_range(0, 3));
            a_sel   = 3'($urandom_range(0, 7));
            a_start = ($urandom_range(0, 3) == 0);
            model_step(a_rst, a_en, a_mode, a_sel, a_start);
            tick();
            chk($sformatf("rand[%0d]", k), {19'd0, a_q, a_idx, a_busy, a_done},
                {19'd0, m_q, 3'(m_idx), m_busy, m_done});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
